// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module sevenseg_scan #(
    parameter int N_DIGITS = 8,
    parameter int CLK_DIV  = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   enable,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*N_DIGITS-1:0] pending_q, pending_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_q, frame_d;

    logic       tick;
    logic       boundary;
    logic [3:0] nib;
    logic       blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'h01;
            4'h1:    hex_to_seg = 7'h4F;
            4'h2:    hex_to_seg = 7'h12;
            4'h3:    hex_to_seg = 7'h06;
            4'h4:    hex_to_seg = 7'h4C;
            4'h5:    hex_to_seg = 7'h24;
            4'h6:    hex_to_seg = 7'h20;
            4'h7:    hex_to_seg = 7'h0F;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h0C;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h60;
            4'hC:    hex_to_seg = 7'h72;
            4'hD:    hex_to_seg = 7'h42;
            4'hE:    hex_to_seg = 7'h30;
            default: hex_to_seg = 7'h38;
        endcase
    endfunction

    assign tick     = (pre_q == PRE_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A load landing on the boundary goes straight to shadow and supersedes any pending value.
    always_comb begin
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        if (boundary) begin
            if (load) begin
                shadow_d = data;
            end else if (pend_flag_q) begin
                shadow_d = pending_q;
            end
            pend_flag_d = 1'b0;
        end else if (load) begin
            pending_d   = data;
            pend_flag_d = 1'b1;
        end
    end

    always_comb begin
        seg_d   = 7'h7F;
        dp_n_d  = 1'b1;
        an_d    = '1;
        frame_d = boundary;
        nib     = shadow_q[{idx_q, 2'b00} +: 4];
        blank   = 1'b0;
`ifdef SEVENSEG_LZB_EN
        blank   = (idx_q != '0) && ((shadow_q >> {idx_q, 2'b00}) == '0);
`endif
        if (enable[idx_q]) begin
            an_d   = ~(N_DIGITS'(1) << idx_q);
            seg_d  = blank ? 7'h7F : hex_to_seg(nib);
            dp_n_d = ~dp[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
            seg_q       <= 7'h7F;
            dp_n_q      <= 1'b1;
            an_q        <= '1;
            frame_q     <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
            seg_q       <= seg_d;
            dp_n_q      <= dp_n_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp_n  = dp_n_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomized bench for sevenseg_scan against a frame-level reference model.
module tb_sevenseg_scan;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        load   = 1'b0;
    logic [15:0] data   = '0;
    logic [3:0]  dp     = '0;
    logic [3:0]  enable = 4'hF;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame;

    int n_pass  = 0;
    int n_total = 0;
    int k       = 0;

    // Latest load seen within each frame; a frame's value is visible from the next frame on.
    logic [15:0] fl_val [256];
    bit          fl_vld [256];

    sevenseg_scan #(.N_DIGITS(N), .CLK_DIV(DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .load   (load),
        .dp     (dp),
        .enable (enable),
        .seg    (seg),
        .dp_n   (dp_n),
        .an     (an),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
    endtask

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h0C;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h72;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    function automatic logic [15:0] shown(input int kk);
        for (int f = kk / FRAME - 1; f >= 0; f--) begin
            if (fl_vld[f]) return fl_val[f];
        end
        return 16'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) fl_vld[i] = 1'b0;
        k = 0;
    endtask

    task automatic check_outputs(input logic [3:0] en_s, input logic [3:0] dp_s);
        logic [15:0] v;
        logic [3:0]  nib;
        logic [3:0]  one;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp;
        int          d;
        bit          blank;
        v     = shown(k);
        d     = (k / DIV) % N;
        nib   = v[4*d +: 4];
        blank = 1'b0;
`ifdef SEVENSEG_LZB_EN
        blank = (d > 0) && ((v >> (4*d)) == 16'h0);
`endif
        one = 4'b0001 << d;
        if (en_s[d]) begin
            exp_an  = ~one;
            exp_seg = blank ? 7'h7F : hex_seg(nib);
            exp_dp  = ~dp_s[d];
        end else begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end
        check_val("an",    32'(an),    32'(exp_an));
        check_val("seg",   32'(seg),   32'(exp_seg));
        check_val("dp_n",  32'(dp_n),  32'(exp_dp));
        check_val("frame", 32'(frame), 32'((k % FRAME) == FRAME - 1));
    endtask

    task automatic step(input bit do_load, input logic [15:0] d_in);
        logic [3:0] en_s;
        logic [3:0] dp_s;
        load = do_load;
        data = do_load ? d_in : 16'($urandom);
        en_s = enable;
        dp_s = dp;
        @(posedge clk);
        if (do_load) begin
            fl_val[k / FRAME] = d_in;
            fl_vld[k / FRAME] = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        check_outputs(en_s, dp_s);
        k++;
    endtask

    task automatic idle_until(input int target);
        while (k < target) step(1'b0, 16'h0);
    endtask

    task automatic reset_cycles(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("rst_seg",   32'(seg),   32'h7F);
            check_val("rst_an",    32'(an),    32'hF);
            check_val("rst_dp_n",  32'(dp_n),  32'h1);
            check_val("rst_frame", 32'(frame), 32'h0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        reset_cycles(3);

        step(1'b1, 16'h1234);
        idle_until(20);
        step(1'b1, 16'hABCD);
        idle_until(25);
        step(1'b1, 16'h5678);
        idle_until(40);
        step(1'b1, 16'h1111);
        idle_until(47);
        step(1'b1, 16'hFFFF);
        idle_until(64);
        enable = 4'b0101;
        dp     = 4'b0001;
        idle_until(80);
        enable = 4'hF;
        dp     = 4'h0;
        idle_until(96);

        for (int i = 0; i < 640; i++) begin
            if (i % 16 == 7) begin
                enable = 4'($urandom);
                dp     = 4'($urandom);
            end
            if ((k % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0)
                step(1'b1, 16'($urandom));
            else
                step($urandom_range(0, 5) == 0, 16'($urandom));
        end

        enable = 4'hF;
        dp     = 4'h0;
        step(1'b1, 16'hBEEF);
        idle_until(k + 5);
        reset_cycles(2);
        idle_until(2 * FRAME);
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 4) == 0, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
